pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencer for the 5-stage RISC-V core (IF, ID, EX, MA, WB). Combines the data-hazard flag from the hazard unit with cache-busy, branch-redirect and multi-cycle mul/div handshakes. Produces per-stage clock enables and tracks one valid bit per stage from ID onward, inserting and removing bubbles. The valid bits gate each stage's write-back enable into the hazard unit and register file. Also keeps a saturating stall-cycle counter for performance analysis.

## Interface
- CNT_W, 16, width of stall-cycle counter
- i_clk  in  1  core clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_hz_data  in  1  unrecoverable data hazard for the instruction in ID
- i_ic_busy  in  1  instruction cache has no instruction for IF this cycle
- i_dc_busy  in  1  data cache cannot complete MA this cycle
- i_br_taken  in  1  branch/jump in EX redirects the PC
- i_md_start  in  1  instruction in EX is mul/div
- i_md_done  in  1  mul/div result valid; level, held until EX advances
- i_cnt_clr  in  1  synchronous clear of stall counter
- o_ce_if, o_ce_id, o_ce_ex, o_ce_ma, o_ce_wb  out  1 each  stage register enables
- o_id_valid, o_ex_valid, o_ma_valid, o_wb_valid  out  1 each  stage holds a real instruction
- o_flush  out  1  PC redirect accepted this cycle
- o_md_busy  out  1  FSM in S_MD
- o_stall_cnt  out  CNT_W  stalled-cycle count

## Operation
- Registers: v_id, v_ex, v_ma, v_wb; FSM state {S_RUN, S_MD}; counter.
- Qualified events:
  - hz = i_hz_data & v_id
  - flush = i_br_taken & v_ex & !i_dc_busy
  - ex_hold = (S_RUN & i_md_start & v_ex & !i_md_done) | (S_MD & !i_md_done)
  - id_hold = (ex_hold | hz) & !flush
- Enables, all combinational:
  - o_ce_wb = o_ce_ma = !i_dc_busy
  - o_ce_ex = !i_dc_busy & !ex_hold
  - o_ce_id = !i_dc_busy & !id_hold
  - o_ce_if = o_ce_id & (!i_ic_busy | flush)
  - o_flush = flush
- Valid update. When i_dc_busy = 1, all v_* hold. Otherwise:
  - v_wb <= v_ma
  - v_ma <= v_ex & !ex_hold
  - v_ex <= ex_hold ? v_ex : (flush | hz) ? 0 : v_id
  - v_id <= flush ? 0 : id_hold ? v_id : !i_ic_busy
- FSM:
  - S_RUN -> S_MD when i_md_start & v_ex & !i_md_done & !i_dc_busy
  - S_MD -> S_RUN when i_md_done & !i_dc_busy
  - Otherwise stay.
- Priorities:
  - dc_busy freezes everything, including a pending branch or md_done; those are re-evaluated next cycle.
  - Flush beats hz: the ID instruction is discarded, not stalled.
  - A branch cannot coexist with ex_hold (mul/div is not a branch), so flush is never asserted during ex_hold.
- Counter: i_cnt_clr -> 0; else increment when o_ce_id = 0, saturating at all-ones.

## Timing
- Reset values:
  - v_* = 0, so all o_*_valid = 0
  - state S_RUN, o_md_busy = 0, o_stall_cnt = 0
  - o_flush = 0
  - With i_dc_busy = 0 and i_ic_busy = 0, o_ce_* = 1.
- Release from reset: the first instruction fetched with i_ic_busy = 0 appears as o_id_valid one cycle later. Without stalls it reaches o_wb_valid 3 cycles after that.
- Hazard stall: each cycle hz = 1 inserts exactly one EX bubble; ID and IF hold.
- Branch taken in EX at cycle N:
  - o_flush = 1 in cycle N.
  - o_id_valid = 0 and o_ex_valid = 0 in cycle N+1.
  - Branch penalty is 2 bubbles.
- Mul/div with done asserted K cycles after start (K ≥ 1):
  - EX frozen for K cycles; K bubbles enter MA.
  - o_md_busy high from cycle start+1 through the done cycle.
- Zero-latency mul/div (start & done in the same cycle): no stall, FSM stays in S_RUN.
- Reset asserted mid-operation: state, valids and counter clear immediately (asynchronous); in-flight instructions are dropped.

## Test plan
- Reset, ic_busy=0, 6 cycles free run -> valids fill ID, EX, MA, WB on cycles 1-4; o_stall_cnt=0.
- i_hz_data=1 for 2 cycles with v_id=1 -> o_ce_id=0 for 2 cycles; 2 bubbles visible on o_ex_valid; o_stall_cnt=2.
- i_br_taken=1 with v_ex=1, i_hz_data=1 in the same cycle -> o_flush=1, o_ce_id=1; next cycle o_id_valid=0 and o_ex_valid=0.
- i_md_start with done after 3 cycles -> o_ce_ex=0 for 3 cycles; o_md_busy=1 for 3 cycles; o_ma_valid=0 for 3 cycles; return to S_RUN.
- i_dc_busy=1 for 4 cycles during a branch -> all o_ce_*=0; o_flush=0 until busy drops; then flush fires once.
- Counter: force 0xFFFE then 3 stall cycles -> holds 0xFFFF; i_cnt_clr concurrent with a stall -> 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stage sequencer for the 5-stage core (IF, ID, EX, MA, WB).
// Merges the data-hazard, cache-busy, branch-redirect and mul/div handshakes
// into per-stage clock enables. It keeps one valid bit per stage from ID
// onward and a saturating stall-cycle counter for performance analysis.
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_hz_data,
    input  logic             i_ic_busy,
    input  logic             i_dc_busy,
    input  logic             i_br_taken,
    input  logic             i_md_start,
    input  logic             i_md_done,
    input  logic             i_cnt_clr,
    output logic             o_ce_if,
    output logic             o_ce_id,
    output logic             o_ce_ex,
    output logic             o_ce_ma,
    output logic             o_ce_wb,
    output logic             o_id_valid,
    output logic             o_ex_valid,
    output logic             o_ma_valid,
    output logic             o_wb_valid,
    output logic             o_flush,
    output logic             o_md_busy,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [0:0] {
        S_RUN = 1'b0,
        S_MD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic             v_id_r;
    logic             v_ex_r;
    logic             v_ma_r;
    logic             v_wb_r;
    logic [CNT_W-1:0] cnt_r;

    logic             hz_s;
    logic             flush_s;
    logic             ex_hold_s;
    logic             id_hold_s;
    logic             ce_id_s;

    // Qualify raw handshakes against stage validity and the mul/div FSM.
    always_comb begin
        hz_s      = i_hz_data & v_id_r;
        flush_s   = i_br_taken & v_ex_r & ~i_dc_busy;
        ex_hold_s = 1'b0;
        case (state_r)
            S_RUN:   ex_hold_s = i_md_start & v_ex_r & ~i_md_done;
            S_MD:    ex_hold_s = ~i_md_done;
            default: ex_hold_s = 1'b0;
        endcase
        // A redirect discards the ID instruction instead of holding it.
        id_hold_s = (ex_hold_s | hz_s) & ~flush_s;
        ce_id_s   = ~i_dc_busy & ~id_hold_s;
    end

    // Mul/div FSM next state; a busy data cache postpones every transition.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_RUN: begin
                if (i_md_start & v_ex_r & ~i_md_done & ~i_dc_busy) begin
                    state_nxt_s = S_MD;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_MD: begin
                if (i_md_done & ~i_dc_busy) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_MD;
                end
            end
            default: state_nxt_s = S_RUN;
        endcase
    end

    // Mul/div FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= S_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Stage valid bits: bubbles enter on hazards, redirects and mul/div holds.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v_id_r <= 1'b0;
            v_ex_r <= 1'b0;
            v_ma_r <= 1'b0;
            v_wb_r <= 1'b0;
        end else if (!i_dc_busy) begin
            v_wb_r <= v_ma_r;
            v_ma_r <= v_ex_r & ~ex_hold_s;
            if (ex_hold_s) begin
                v_ex_r <= v_ex_r;
            end else if (flush_s | hz_s) begin
                v_ex_r <= 1'b0;
            end else begin
                v_ex_r <= v_id_r;
            end
            if (flush_s) begin
                v_id_r <= 1'b0;
            end else if (id_hold_s) begin
                v_id_r <= v_id_r;
            end else begin
                v_id_r <= ~i_ic_busy;
            end
        end else begin
            v_id_r <= v_id_r;
            v_ex_r <= v_ex_r;
            v_ma_r <= v_ma_r;
            v_wb_r <= v_wb_r;
        end
    end

    // Saturating count of cycles in which ID does not advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (i_cnt_clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!ce_id_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_ce_wb     = ~i_dc_busy;
    assign o_ce_ma     = ~i_dc_busy;
    assign o_ce_ex     = ~i_dc_busy & ~ex_hold_s;
    assign o_ce_id     = ce_id_s;
    assign o_ce_if     = ce_id_s & (~i_ic_busy | flush_s);
    assign o_flush     = flush_s;
    assign o_id_valid  = v_id_r;
    assign o_ex_valid  = v_ex_r;
    assign o_ma_valid  = v_ma_r;
    assign o_wb_valid  = v_wb_r;
    assign o_md_busy   = (state_r == S_MD);
    assign o_stall_cnt = cnt_r;

endmodule
